// File: rtl/tftlcd_timing_gen.sv
// TFT-LCD raster timing generator: h/v counters, registered sync/DE/coordinate decode, frame tick.
// Optional colour-bar test pattern on out_rgb when TFTLCD_TIMING_PATTERN_EN is defined.
module tftlcd_timing_gen #(
    parameter int H_ACTIVE  = 480,
    parameter int H_FP      = 50,
    parameter int H_SYNC    = 4,
    parameter int H_BP      = 26,
    parameter int V_ACTIVE  = 272,
    parameter int V_FP      = 20,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 1,
    parameter bit HS_POL    = 1'b0,
    parameter bit VS_POL    = 1'b0,
    parameter int FRAME_DIV = 60,
    parameter int XY_W      = 10
) (
    input  logic            in_clk,
    input  logic            in_rst_n,
    input  logic            in_enable,
    output logic            out_de,
    output logic            out_hsync,
    output logic            out_vsync,
    output logic [XY_W-1:0] out_pixelx,
    output logic [XY_W-1:0] out_pixely,
    output logic            out_frame_tick,
    output logic            out_busy,
`ifdef TFTLCD_TIMING_PATTERN_EN
    output logic [23:0]     out_rgb,
`endif
    output logic            out_clk
);
    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ACTIVE;

    if (H_ACTIVE >= (1 << XY_W) || V_ACTIVE >= (1 << XY_W) ||
        H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        FRAME_DIV < 1 || FRAME_DIV > 1023) begin : g_bad_params
        $error("tftlcd_timing_gen: illegal parameter set");
    end

    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [HW-1:0]   h;
    logic [VW-1:0]   v;
    logic [9:0]      fcnt;
    logic            h_last, v_last, at_origin, active;
    logic            h_in, v_in, de_c;

    assign h_last    = (h == HW'(H_TOTAL - 1));
    assign v_last    = (v == VW'(V_TOTAL - 1));
    assign at_origin = (h == '0) && (v == '0);
    assign active    = (state != IDLE);
    assign h_in      = (h >= HW'(H_START)) && (h < HW'(H_END));
    assign v_in      = (v >= VW'(V_START)) && (v < VW'(V_END));
    assign de_c      = active && h_in && v_in;

    // Gated so the panel sees no clock while held in reset.
    assign out_clk = in_clk & in_rst_n;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (in_enable) state_nxt = RUN;
            RUN:      if (!in_enable) state_nxt = STOPPING;
            STOPPING: begin
                if (in_enable)             state_nxt = RUN;
                else if (h_last && v_last) state_nxt = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Counters sit at 0 in IDLE so the first RUN cycle is h=0, v=0.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            h <= '0;
            v <= '0;
        end else if (!active) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n)
            fcnt <= '0;
        else if (!active || state_nxt == IDLE)
            fcnt <= '0;
        else if (at_origin)
            fcnt <= (fcnt == 10'(FRAME_DIV - 1)) ? '0 : fcnt + 10'd1;
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            out_de         <= 1'b0;
            out_hsync      <= ~HS_POL;
            out_vsync      <= ~VS_POL;
            out_pixelx     <= '0;
            out_pixely     <= '0;
            out_frame_tick <= 1'b0;
            out_busy       <= 1'b0;
        end else begin
            out_de         <= de_c;
            out_hsync      <= (active && h < HW'(H_SYNC)) ? HS_POL : ~HS_POL;
            out_vsync      <= (active && v < VW'(V_SYNC)) ? VS_POL : ~VS_POL;
            out_pixelx     <= de_c ? XY_W'(h - HW'(H_START)) : '0;
            out_pixely     <= de_c ? XY_W'(v - VW'(V_START)) : '0;
            out_frame_tick <= active && at_origin && (fcnt == '0);
            out_busy       <= active;
        end
    end

`ifdef TFTLCD_TIMING_PATTERN_EN
    localparam int BAR_W = H_ACTIVE / 8;
    logic [HW-1:0] px_c;
    logic [2:0]    bar;
    logic [23:0]   color;

    assign px_c = h - HW'(H_START);

    // The last bar also takes any remainder columns.
    always_comb begin
        bar = 3'd0;
        for (int i = 1; i < 8; i++)
            if (int'(px_c) >= i * BAR_W) bar = 3'(i);
    end

    always_comb begin
        color = 24'h000000;
        case (bar)
            3'd0: color = 24'hFFFFFF;
            3'd1: color = 24'hFFFF00;
            3'd2: color = 24'h00FFFF;
            3'd3: color = 24'h00FF00;
            3'd4: color = 24'hFF00FF;
            3'd5: color = 24'hFF0000;
            3'd6: color = 24'h0000FF;
            default: color = 24'h000000;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) out_rgb <= '0;
        else           out_rgb <= de_c ? color : 24'h000000;
    end
`endif
endmodule

// File: tb/tb_tftlcd_timing_gen.sv
// Bench for tftlcd_timing_gen: hand-computed vector table, directed stop/restart/reset
// sequences, and randomized enable/reset traffic checked against a frame-position model.
module tb_tftlcd_timing_gen;
    localparam int HA = 8, HF = 2, HS = 1, HB = 1;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int FD = 2, XW = 10;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FLEN = HT * VT;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          de, hsync, vsync, tick, busy, oclk;
    logic [XW-1:0] px, py;
`ifdef TFTLCD_TIMING_PATTERN_EN
    logic [23:0]   rgb;
`endif

    tftlcd_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .FRAME_DIV(FD), .XY_W(XW)
    ) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_enable(en),
        .out_de(de), .out_hsync(hsync), .out_vsync(vsync),
        .out_pixelx(px), .out_pixely(py),
        .out_frame_tick(tick), .out_busy(busy),
`ifdef TFTLCD_TIMING_PATTERN_EN
        .out_rgb(rgb),
`endif
        .out_clk(oclk)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_miss = 0;

    // Reference model: position within the frame plus a pending-stop flag.
    int m_active, m_stop, m_pos, m_frames;
    logic        e_de, e_hs, e_vs, e_tick, e_busy;
    int          e_px, e_py;
    logic [23:0] e_rgb;

    typedef struct {
        int   pos;
        logic de, hs, vs;
        int   px, py;
        logic tk;
    } vec_t;
    vec_t rows[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_model();
        m_active = 0; m_stop = 0; m_pos = 0; m_frames = 0;
        e_de = 0; e_hs = 1; e_vs = 1; e_px = 0; e_py = 0;
        e_tick = 0; e_busy = 0; e_rgb = 24'h0;
    endtask

    function automatic logic [23:0] bar_color(input int x);
        logic [23:0] tbl [8];
        int b;
        tbl = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
        b = x / (HA / 8);
        if (b > 7) b = 7;
        return tbl[b];
    endfunction

    task automatic model_edge(input logic en_v);
        int h, v;
        if (!rst_n) begin
            reset_model();
            return;
        end
        h = m_pos % HT;
        v = m_pos / HT;
        if (m_active != 0) begin
            e_busy = 1;
            e_hs   = (h < HS) ? 1'b0 : 1'b1;
            e_vs   = (v < VS) ? 1'b0 : 1'b1;
            e_de   = (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
            e_px   = e_de ? h - (HS + HB) : 0;
            e_py   = e_de ? v - (VS + VB) : 0;
            e_rgb  = e_de ? bar_color(e_px) : 24'h0;
            e_tick = (m_pos == 0) && (m_frames % FD == 0);
            if (m_pos == 0) m_frames++;
        end else begin
            e_busy = 0; e_hs = 1; e_vs = 1; e_de = 0;
            e_px = 0; e_py = 0; e_rgb = 24'h0; e_tick = 0;
        end
        if (m_active == 0) begin
            if (en_v) begin
                m_active = 1; m_pos = 0; m_stop = 0; m_frames = 0;
            end
        end else if (m_stop != 0 && !en_v && m_pos == FLEN - 1) begin
            m_active = 0; m_pos = 0; m_stop = 0; m_frames = 0;
        end else begin
            m_pos  = (m_pos + 1) % FLEN;
            m_stop = en_v ? 0 : 1;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".de"},    32'(de),    32'(e_de));
        check({tag, ".hsync"}, 32'(hsync), 32'(e_hs));
        check({tag, ".vsync"}, 32'(vsync), 32'(e_vs));
        check({tag, ".px"},    32'(px),    32'(e_px));
        check({tag, ".py"},    32'(py),    32'(e_py));
        check({tag, ".tick"},  32'(tick),  32'(e_tick));
        check({tag, ".busy"},  32'(busy),  32'(e_busy));
`ifdef TFTLCD_TIMING_PATTERN_EN
        check({tag, ".rgb"},   32'(rgb),   32'(e_rgb));
`endif
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input logic en_v);
        en = en_v;
        @(posedge clk);
        model_edge(en_v);
        #1 check("out_clk", 32'(oclk), 32'(rst_n));
        @(negedge clk);
        check_all("model");
    endtask

    task automatic async_reset(input int hold);
        #2 rst_n = 1'b0;
        #1 reset_model();
        check_all("async_rst");
        for (int i = 0; i < hold; i++) step(1'($urandom_range(0, 1)));
        rst_n = 1'b1;
    endtask

    initial begin
        int opos;
        rows[0]  = '{0,   1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
        rows[1]  = '{1,   1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        rows[2]  = '{11,  1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        rows[3]  = '{12,  1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
        rows[4]  = '{25,  1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        rows[5]  = '{26,  1'b1, 1'b1, 1'b1, 0, 0, 1'b0};
        rows[6]  = '{27,  1'b1, 1'b1, 1'b1, 1, 0, 1'b0};
        rows[7]  = '{33,  1'b1, 1'b1, 1'b1, 7, 0, 1'b0};
        rows[8]  = '{34,  1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        rows[9]  = '{45,  1'b1, 1'b1, 1'b1, 7, 1, 1'b0};
        rows[10] = '{69,  1'b1, 1'b1, 1'b1, 7, 3, 1'b0};
        rows[11] = '{74,  1'b0, 1'b1, 1'b1, 0, 0, 1'b0};
        rows[12] = '{84,  1'b0, 1'b0, 1'b0, 0, 0, 1'b0};
        rows[13] = '{168, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1};

        reset_model();
        @(negedge clk);
        check_all("in_reset");
        repeat (3) step(1'b1);
        rst_n = 1'b1;
        repeat (2) step(1'b0);

        // Enable held high: compare against hand-computed frame positions.
        step(1'b1);
        opos = -1;
        for (int r = 0; r < 14; r++) begin
            while (opos < rows[r].pos) begin
                step(1'b1);
                opos++;
            end
            check($sformatf("tbl%0d.de", rows[r].pos),   32'(de),    32'(rows[r].de));
            check($sformatf("tbl%0d.hs", rows[r].pos),   32'(hsync), 32'(rows[r].hs));
            check($sformatf("tbl%0d.vs", rows[r].pos),   32'(vsync), 32'(rows[r].vs));
            check($sformatf("tbl%0d.px", rows[r].pos),   32'(px),    32'(rows[r].px));
            check($sformatf("tbl%0d.py", rows[r].pos),   32'(py),    32'(rows[r].py));
            check($sformatf("tbl%0d.tick", rows[r].pos), 32'(tick),  32'(rows[r].tk));
`ifdef TFTLCD_TIMING_PATTERN_EN
            if (rows[r].pos == 26) check("tbl26.rgb", 32'(rgb), 32'h00FFFFFF);
            if (rows[r].pos == 33) check("tbl33.rgb", 32'(rgb), 32'h00000000);
            if (rows[r].pos == 34) check("tbl34.rgb", 32'(rgb), 32'h00000000);
`endif
        end

        // Enable dropped at frame cycle 30: frame completes, then IDLE.
        async_reset(2);
        step(1'b1);
        repeat (30) step(1'b1);
        repeat (54) step(1'b0);
        check("stop.busy_hold", 32'(busy), 32'd1);
        step(1'b0);
        check("stop.busy_idle", 32'(busy),  32'd0);
        check("stop.de",        32'(de),    32'd0);
        check("stop.hsync",     32'(hsync), 32'd1);
        check("stop.vsync",     32'(vsync), 32'd1);

        // Dropped at 30, restored at 40: uninterrupted, ticks on schedule.
        step(1'b1);
        for (int j = 1; j <= 170; j++) begin
            step((j >= 31 && j <= 40) ? 1'b0 : 1'b1);
            check("resume.busy", 32'(busy), 32'd1);
            check("resume.tick", 32'(tick), 32'((j - 1 == 0) || (j - 1 == 168)));
        end

        // Reset mid-frame, then restart from the origin.
        async_reset(1);
        step(1'b1);
        repeat (50) step(1'b1);
        async_reset(2);
        step(1'b1);
        step(1'b1);
        check("restart.hsync", 32'(hsync), 32'd0);
        check("restart.vsync", 32'(vsync), 32'd0);
        check("restart.tick",  32'(tick),  32'd1);
        check("restart.busy",  32'(busy),  32'd1);

        // Randomized enable traffic with occasional asynchronous resets.
        for (int s = 0; s < 40; s++) begin
            logic ev;
            int   len;
            ev  = ($urandom_range(0, 3) != 0);
            len = ev ? $urandom_range(1, 200) : $urandom_range(1, 60);
            for (int i = 0; i < len; i++) step(ev);
            if ($urandom_range(0, 9) == 0) async_reset($urandom_range(1, 3));
        end
        repeat (2 * FLEN) step(1'b0);
        check("final.busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
